// File: rtl/branch_fetch_if.sv
// Fetch-stage bus bundle: instruction memory req/ack port, decode valid/ready port
// and branch-resolution inputs. The fetch unit is the master.
interface branch_fetch_if;
    // Handshakes: imem_req is held with a stable imem_addr until a 1-cycle imem_ack
    // (data valid in the ack cycle); decode takes instr when instr_valid & instr_ready.
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic        br_taken;
    logic [63:0] br_pc;
    logic [63:0] br_offset;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, br_valid, br_taken, br_pc, br_offset
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready, br_valid, br_taken, br_pc, br_offset
    );
endinterface

// File: rtl/branch_fetch_unit.sv
// LEGv8 instruction fetch stage: PC, memory fetch, decode hand-off, branch redirect.
// Optional FETCH_PERF_CNT_EN adds saturating accepted/flush counters.
module branch_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_fetch_if.master       bus,
    output logic [1:0]           dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetch_cnt,
    output logic [31:0]          perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [63:0] RESET_PC_ALIGNED = RESET_PC & ~64'h3;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] instr_pc_q, instr_pc_d;
    logic        redirect;
    logic [63:0] target;
    logic [63:0] pc_inc;
    logic        accept_fire;
    logic        flush_fire;

    assign redirect = bus.br_valid & bus.br_taken;
    assign target   = bus.br_pc + (bus.br_offset << 2);
    assign pc_inc   = pc_q + 64'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC_ALIGNED;
            addr_q     <= 64'h0;
            instr_q    <= 32'h0;
            instr_pc_q <= 64'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        accept_fire = 1'b0;
        flush_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                addr_d  = pc_q;
            end
            FETCH: begin
                if (redirect) begin
                    flush_fire = 1'b1;
                    pc_d       = target;
                    if (bus.imem_ack) addr_d  = target;
                    else              state_d = DRAIN;
                end else if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            DRAIN: begin
                // The outstanding request must complete at its original address;
                // only the PC follows further redirects.
                if (redirect) begin
                    flush_fire = 1'b1;
                    pc_d       = target;
                end
                if (bus.imem_ack) begin
                    state_d = FETCH;
                    addr_d  = redirect ? target : pc_q;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush_fire = 1'b1;
                    pc_d       = target;
                    addr_d     = target;
                    state_d    = FETCH;
                end else if (bus.instr_ready) begin
                    accept_fire = 1'b1;
                    pc_d        = pc_inc;
                    addr_d      = pc_inc;
                    state_d     = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
        bus.imem_addr   = addr_q;
        bus.instr_valid = (state_q == HOLD);
        bus.instr       = instr_q;
        bus.instr_pc    = instr_pc_q;
        dbg_state       = state_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (accept_fire && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (flush_fire  && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = accept_fire ^ flush_fire;
`endif

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Directed bench for branch_fetch_unit (RESET_PC=64'h40) with a delivery scoreboard.
module tb_branch_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    logic [1:0] dbg_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    branch_fetch_if bus ();

    branch_fetch_unit #(.RESET_PC(64'h40)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .dbg_state      (dbg_state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [95:0] exp_q[$];  // {instr_pc, instr}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare any completed decode handshake against the scoreboard, then advance one cycle.
    task automatic step();
        logic [95:0] e;
        if (!reset && bus.instr_valid && bus.instr_ready && !(bus.br_valid && bus.br_taken)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr_pc", bus.instr_pc, e[95:32]);
                chk("sb_instr", {32'h0, bus.instr}, {32'h0, e[31:0]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ack_word(input logic [31:0] d, input bit deliver, input logic [63:0] pc);
        if (deliver) exp_q.push_back({pc, d});
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = d;
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'($urandom_range(0, 32'hFFFF));
    endtask

    task automatic branch(input logic [63:0] pc, input logic [63:0] off, input logic taken);
        bus.br_valid  = 1'b1;
        bus.br_taken  = taken;
        bus.br_pc     = pc;
        bus.br_offset = off;
    endtask

    task automatic no_branch();
        bus.br_valid = 1'b0;
        bus.br_taken = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        bus.br_valid    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_pc       = 64'h0;
        bus.br_offset   = 64'h0;
        step();
        step();
        chk("rst_req", 64'(bus.imem_req), 64'd0);
        chk("rst_addr", bus.imem_addr, 64'h0);
        chk("rst_instr", 64'(bus.instr), 64'h0);
        chk("rst_instr_pc", bus.instr_pc, 64'h0);
        chk("rst_valid", 64'(bus.instr_valid), 64'd0);

        // First fetch from RESET_PC, ack after 2 cycles.
        reset = 1'b0;
        step();
        chk("first_req", 64'(bus.imem_req), 64'd1);
        chk("first_addr", bus.imem_addr, 64'h40);
        step();
        step();
        chk("first_addr_stable", bus.imem_addr, 64'h40);
        bus.instr_ready = 1'b1;
        ack_word(32'h9100_0421, 1'b1, 64'h40);
        chk("first_valid", 64'(bus.instr_valid), 64'd1);
        chk("first_instr_pc", bus.instr_pc, 64'h40);
        chk("first_instr", 64'(bus.instr), 64'h9100_0421);
        chk("hold_req_low", 64'(bus.imem_req), 64'd0);
        step();
        chk("seq_addr", bus.imem_addr, 64'h44);
        chk("seq_valid_low", 64'(bus.instr_valid), 64'd0);

        // Taken branch while holding: 0x100 + (-2 << 2) = 0xF8.
        ack_word(32'hAAAA_5555, 1'b0, 64'h44);
        branch(64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        step();
        no_branch();
        chk("hold_flush_valid", 64'(bus.instr_valid), 64'd0);
        chk("hold_flush_req", 64'(bus.imem_req), 64'd1);
        chk("hold_flush_addr", bus.imem_addr, 64'hF8);

        // Redirect without ack: 0x1F0 + (4 << 2) = 0x200; old request drains first.
        branch(64'h1F0, 64'h4, 1'b1);
        step();
        no_branch();
        chk("drain_req", 64'(bus.imem_req), 64'd1);
        chk("drain_addr", bus.imem_addr, 64'hF8);
        step();
        step();
        chk("drain_addr_late", bus.imem_addr, 64'hF8);
        ack_word(32'hDEAD_BEEF, 1'b0, 64'hF8);
        chk("drain_no_valid", 64'(bus.instr_valid), 64'd0);
        chk("drain_target_addr", bus.imem_addr, 64'h200);

        // Decode backpressure for 5 cycles.
        bus.instr_ready = 1'b0;
        ack_word(32'h8B02_0020, 1'b1, 64'h200);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 64'(bus.instr_valid), 64'd1);
            chk("bp_req", 64'(bus.imem_req), 64'd0);
            chk("bp_instr", 64'(bus.instr), 64'h8B02_0020);
            chk("bp_instr_pc", bus.instr_pc, 64'h200);
        end
        bus.instr_ready = 1'b1;
        step();
        chk("bp_next_addr", bus.imem_addr, 64'h204);

        // Not-taken branch has no effect, both in FETCH and in HOLD.
        branch(64'h500, 64'h0, 1'b0);
        ack_word(32'hD280_0000, 1'b1, 64'h204);
        chk("nt_valid", 64'(bus.instr_valid), 64'd1);
        chk("nt_instr_pc", bus.instr_pc, 64'h204);
        step();
        no_branch();
        chk("nt_next_addr", bus.imem_addr, 64'h208);

        // Ack and redirect together, to the last word before wrap.
        branch(64'hFFFF_FFFF_FFFF_FFF0, 64'h3, 1'b1);
        ack_word(32'hCAFE_F00D, 1'b0, 64'h208);
        no_branch();
        chk("ackredir_valid", 64'(bus.instr_valid), 64'd0);
        chk("ackredir_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        ack_word(32'h1400_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        chk("wrap_addr", bus.imem_addr, 64'h0);

        // Reset in DRAIN, with an ack in the reset cycle.
        branch(64'h300, 64'h0, 1'b1);
        step();
        no_branch();
        chk("pre_rst_drain_addr", bus.imem_addr, 64'h0);
        reset          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0BAD_0BAD;
        step();
        bus.imem_ack = 1'b0;
        chk("mid_rst_req", 64'(bus.imem_req), 64'd0);
        chk("mid_rst_addr", bus.imem_addr, 64'h0);
        chk("mid_rst_instr", 64'(bus.instr), 64'h0);
        chk("mid_rst_instr_pc", bus.instr_pc, 64'h0);
        chk("mid_rst_valid", 64'(bus.instr_valid), 64'd0);
        reset = 1'b0;
        step();
        chk("restart_addr", bus.imem_addr, 64'h40);
        chk("restart_valid", 64'(bus.instr_valid), 64'd0);

        // Three accepted instructions and one flush after reset.
        ack_word(32'h0000_0001, 1'b1, 64'h40);
        step();
        ack_word(32'h0000_0002, 1'b1, 64'h44);
        step();
        ack_word(32'h0000_0003, 1'b1, 64'h48);
        step();
        chk("cnt_seq_addr", bus.imem_addr, 64'h4C);
        branch(64'h400, 64'h0, 1'b1);
        step();
        no_branch();
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'd3);
        chk("perf_flush_cnt", 64'(perf_flush_cnt), 64'd1);
`endif
        ack_word(32'h0000_0004, 1'b0, 64'h4C);
        chk("final_addr", bus.imem_addr, 64'h400);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
